// File: rtl/demux32_1_2.sv
// 1:2 streaming demultiplexer: each input word is routed by Sel into one of two
// independent FIFOs (A when Sel=1, B when Sel=0), each with a saturating push counter.

module demux32_1_2_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             full,
  output logic [15:0]      cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      occ;
  logic             pop;

  assign valid = (occ != '0);
  assign full  = (occ == FULL_OCC);
  assign pop   = valid & pop_ready;
  assign head  = mem[rd_ptr];

  // NOTE: storage has no reset; occupancy alone decides what is valid, so the
  // array can map onto plain RAM without a clear path.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      cnt    <= '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (push && cnt != 16'hFFFF) cnt <= cnt + 1'b1;
    end
  end

endmodule

module demux32_1_2 #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] I,
  input  logic             I_valid,
  output logic             I_ready,
  input  logic             Sel,
  output logic [WIDTH-1:0] A,
  output logic             A_valid,
  input  logic             A_ready,
  output logic [15:0]      A_cnt,
  output logic [WIDTH-1:0] B,
  output logic             B_valid,
  input  logic             B_ready,
  output logic [15:0]      B_cnt
);

  logic a_full;
  logic b_full;
  logic accept;
  logic push_a;
  logic push_b;

  // A full FIFO still takes a word when its head leaves on the same edge; the
  // rst term presents the post-reset (empty) view while reset is held.
  assign I_ready = rst | (Sel ? (~a_full | A_ready) : (~b_full | B_ready));
  assign accept  = I_valid & I_ready & ~rst;
  assign push_a  = accept &  Sel;
  assign push_b  = accept & ~Sel;

  demux32_1_2_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
    .clk       (clk),
    .rst       (rst),
    .push      (push_a),
    .wdata     (I),
    .pop_ready (A_ready),
    .head      (A),
    .valid     (A_valid),
    .full      (a_full),
    .cnt       (A_cnt)
  );

  demux32_1_2_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
    .clk       (clk),
    .rst       (rst),
    .push      (push_b),
    .wdata     (I),
    .pop_ready (B_ready),
    .head      (B),
    .valid     (B_valid),
    .full      (b_full),
    .cnt       (B_cnt)
  );

endmodule

// File: doc/demux32_1_2.md
DEMUX32_1_2 -- requirements
Module: demux32_1_2

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits.
REQ-002 Parameter DEPTH, default 4, entries per output FIFO; power of two, 2..16.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 I  input  WIDTH  input data word.
REQ-006 I_valid  input  1  I holds a word to deliver.
REQ-007 I_ready  output  1  the block accepts I this cycle.
REQ-008 Sel  input  1  destination select, sampled with I: 1 routes to A, 0 routes to B.
REQ-009 A / B  output  WIDTH each  head word of the A / B FIFO.
REQ-010 A_valid / B_valid  output  1 each  the A / B FIFO is non-empty.
REQ-011 A_ready / B_ready  input  1 each  the downstream consumer takes the head word this cycle.
REQ-012 A_cnt / B_cnt  output  16 each  saturating count of words accepted into A / B since reset.

Function
REQ-013 The block shall contain two independent FIFOs, A and B, each DEPTH x WIDTH, with binary read and write pointers and an occupancy counter of log2(DEPTH)+1 bits.
REQ-014 Input accept shall occur when I_valid and I_ready are both 1 on a rising edge.
- Sel=1: I is written to the A FIFO.
- Sel=0: I is written to the B FIFO.
REQ-015 I_ready shall be combinational: high when the FIFO selected by the current Sel is not full, or is full and its head is being popped in the same cycle.
REQ-016 I_ready shall not depend on I_valid.
REQ-017 An output pop shall occur when X_valid and X_ready are both 1 on a rising edge (X = A or B).
- The read pointer advances, modulo DEPTH.
REQ-018 X shall show the FIFO head combinationally from the storage array.
- Latency: a word accepted at edge n appears on X with X_valid=1 after edge n, provided the FIFO was empty.
- Minimum latency is 1 cycle; there is no bypass path.
REQ-019 Occupancy shall change as follows on each edge:
- push only: +1
- pop only: -1
- push and pop on the same FIFO: unchanged, with both pointers advancing.
REQ-020 Pointers shall wrap from DEPTH-1 to 0 without a bubble.
REQ-021 Full (occupancy = DEPTH) shall block pushes through I_ready only.
- A push toward the other FIFO shall stay possible; there is no head-of-line blocking across destinations.
REQ-022 Empty (occupancy = 0) shall drive X_valid=0.
- X is don't-care while empty.
- X_ready while empty shall have no effect.
REQ-023 Words to the same destination shall leave in acceptance order.
- No ordering holds between A and B.
REQ-024 X_cnt shall increment by 1 on each push into X and saturate at 16'hFFFF.
REQ-025 Changing Sel while I_valid=1 and I_ready=0 shall be legal.
- The word routes by Sel in the cycle it is accepted.
REQ-026 No word shall be duplicated or dropped while rst=0.

Reset
REQ-027 When rst=1 at a rising edge, the block shall:
- clear all pointers, occupancies, A_cnt and B_cnt to 0;
- drive A_valid=0 and B_valid=0 from the next cycle.
REQ-028 Reset shall take priority over simultaneous pushes and pops.
- Words in flight or stored are discarded.
- Storage contents are not cleared.
REQ-029 During rst=1, I_ready shall follow REQ-015 using the cleared state, i.e. it shall be 1.
- Words presented during reset are not accepted and not counted.

Verification
REQ-030 Route test: after reset, push 32'h0000_0001 with Sel=1, then 32'h0000_0002 with Sel=0, A_ready=B_ready=0.
- Required: A=1 with A_valid=1; B=2 with B_valid=1; A_cnt=1; B_cnt=1.
REQ-031 Full/no-blocking test (DEPTH=4): push 4 words with Sel=1 and A_ready=0.
- Required: I_ready=0 while Sel=1.
- Then set Sel=0: I_ready=1 and a push into B succeeds.
REQ-032 Simultaneous push/pop at full: A full, Sel=1, I_valid=1, A_ready=1.
- Required: I_ready=1; A occupancy stays 4; pops return words in push order.
REQ-033 Wrap test: stream 10 words 32'hA0..32'hA9 into A with A_ready=1 throughout.
- Required: A emits A0..A9 in order, 1-cycle latency each, no gaps.
REQ-034 Reset mid-operation: B holds 3 words; assert rst for 1 cycle with I_valid=1.
- Required: next cycle B_valid=0, B_cnt=0, and the presented word is not delivered.
REQ-035 Saturation: force 65 537 pushes into B with B_ready=1.
- Required: B_cnt=16'hFFFF and holds that value.
